// File: rtl/gate_arbiter.sv
// Shared-barrier lane controller: arbitrates entry/exit requests, blocks
// entry at capacity, and sequences the barrier through raise/open/lower.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   entry_req, exit_req   : debounced loop-presence levels
//   carIn, carOut         : one-cycle passage-complete pulses
//   occupancy             : current car count from the counter
//   barrier_up/down       : motor commands (registered, never both high)
//   lane_dir              : 00 none, 01 entry granted, 10 exit granted
//   full                  : combinational occupancy >= CAPACITY
//   timeout_err           : one-cycle pulse when the open hold expires
module gate_arbiter #(
    parameter int CNT_W          = 3,
    parameter int CAPACITY       = 7,
    parameter int MOVE_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             carIn,
    input  logic             carOut,
    input  logic [CNT_W-1:0] occupancy,
    output logic             barrier_up,
    output logic             barrier_down,
    output logic [1:0]       lane_dir,
    output logic             full,
    output logic             timeout_err
);

    localparam int MAXC = (MOVE_CYCLES > TIMEOUT_CYCLES) ?
                          MOVE_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAXC + 1);

    localparam logic [TW-1:0]    MOVE_LD = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0]    HOLD_LD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]    ONE     = TW'(1);
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_ENTRY = 2'b01;
    localparam logic [1:0] DIR_EXIT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RAISE,
        OPEN,
        LOWER
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic            r_last_exit;
    logic            r_up;
    logic            r_down;
    logic [1:0]      r_lane_dir;
    logic            r_timeout_err;

    logic            w_full;
    logic            w_entry_ok;
    logic            w_exit_ok;
    logic            w_grant_exit;
    logic            w_pass;
    logic            w_tdone;

    assign w_full     = (occupancy >= CAP);
    assign w_entry_ok = entry_req & ~w_full;
    assign w_exit_ok  = exit_req;

    // Exit wins when it is the only candidate, or on a tie when the
    // previous grant went to entry (round-robin).
    assign w_grant_exit = w_exit_ok & (~w_entry_ok | ~r_last_exit);

    // Only the pulse matching the latched grant closes the barrier.
    assign w_pass  = r_lane_dir[1] ? carOut : carIn;
    assign w_tdone = (r_timer == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_last_exit   <= 1'b1;
            r_up          <= 1'b0;
            r_down        <= 1'b0;
            r_lane_dir    <= DIR_NONE;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_entry_ok | w_exit_ok) begin
                        r_state     <= RAISE;
                        r_timer     <= MOVE_LD;
                        r_last_exit <= w_grant_exit;
                        r_lane_dir  <= w_grant_exit ? DIR_EXIT : DIR_ENTRY;
                        r_up        <= 1'b1;
                    end
                end
                RAISE: begin
                    if (w_tdone) begin
                        r_state <= OPEN;
                        r_timer <= HOLD_LD;
                        r_up    <= 1'b0;
                    end else begin
                        r_timer <= r_timer - ONE;
                    end
                end
                OPEN: begin
                    // A pass in the final hold cycle beats the timeout.
                    if (w_pass | w_tdone) begin
                        r_state       <= LOWER;
                        r_timer       <= MOVE_LD;
                        r_down        <= 1'b1;
                        r_timeout_err <= ~w_pass;
                    end else begin
                        r_timer <= r_timer - ONE;
                    end
                end
                LOWER: begin
                    if (w_tdone) begin
                        r_state    <= IDLE;
                        r_down     <= 1'b0;
                        r_lane_dir <= DIR_NONE;
                    end else begin
                        r_timer <= r_timer - ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign barrier_up   = r_up;
    assign barrier_down = r_down;
    assign lane_dir     = r_lane_dir;
    assign full         = w_full;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_gate_arbiter.sv
// Bench for gate_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against a schedule-based reference model.
module tb_gate_arbiter;

    localparam int M   = 4;
    localparam int T   = 20;
    localparam int CAP = 7;
    localparam int W   = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         entry_req = 1'b0;
    logic         exit_req = 1'b0;
    logic         carIn = 1'b0;
    logic         carOut = 1'b0;
    logic [W-1:0] occupancy = '0;
    logic         barrier_up;
    logic         barrier_down;
    logic [1:0]   lane_dir;
    logic         full;
    logic         timeout_err;

    always #5 clk = ~clk;

    gate_arbiter #(
        .CNT_W(W),
        .CAPACITY(CAP),
        .MOVE_CYCLES(M),
        .TIMEOUT_CYCLES(T)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .entry_req(entry_req),
        .exit_req(exit_req),
        .carIn(carIn),
        .carOut(carOut),
        .occupancy(occupancy),
        .barrier_up(barrier_up),
        .barrier_down(barrier_down),
        .lane_dir(lane_dir),
        .full(full),
        .timeout_err(timeout_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    endtask

    // Reference model: a sequence is described by its first RAISE cycle
    // (m_t0) and the cycle lowering starts (m_low, -1 while still open).
    bit m_known    = 0;
    bit m_busy     = 0;
    bit m_last_exit = 1;
    bit m_dir_exit = 0;
    bit m_tout     = 0;
    int m_t0       = 0;
    int m_low      = -1;

    // Stimulus knobs
    bit k_rand  = 0;
    bit k_rst   = 0;
    bit k_en    = 0;
    bit k_ex    = 0;
    int k_occ   = 0;
    int k_pass  = -1;
    int k_wrong = -1;

    // Observations of the DUT for directed checks
    int obs_open = 0;
    int obs_err  = 0;
    int glog[$];
    logic [1:0] prev_lane = 2'b00;

    function automatic bit in_open();
        return m_busy && (cyc >= m_t0 + M) && (m_low < 0);
    endfunction

    task automatic step();
        int k;
        bit eo, xo, dx, ps;
        int e_up, e_dn, e_lane, e_err;
        @(negedge clk);
        carIn  = 1'b0;
        carOut = 1'b0;
        if (k_rand) begin
            reset     = ($urandom_range(0, 99) == 0);
            entry_req = 1'($urandom_range(0, 1));
            exit_req  = 1'($urandom_range(0, 1));
            occupancy = W'($urandom_range(0, 7));
            carIn     = ($urandom_range(0, 9) == 0);
            carOut    = ($urandom_range(0, 9) == 0);
        end else begin
            reset     = k_rst;
            entry_req = k_en;
            exit_req  = k_ex;
            occupancy = W'(k_occ);
            if (in_open()) begin
                k = cyc - m_t0 - M;
                if (k == k_pass) begin
                    if (m_dir_exit) carOut = 1'b1;
                    else carIn = 1'b1;
                end
                if (k == k_wrong) begin
                    if (m_dir_exit) carIn = 1'b1;
                    else carOut = 1'b1;
                end
            end
        end
        #1;
        chk("full", int'(full), int'(int'(occupancy) >= CAP));
        if (m_known) begin
            e_up   = int'(m_busy && cyc < m_t0 + M);
            e_dn   = int'(m_busy && m_low >= 0 && cyc >= m_low);
            e_lane = m_busy ? (m_dir_exit ? 2 : 1) : 0;
            e_err  = int'(m_busy && m_low == cyc && m_tout);
            chk("barrier_up", int'(barrier_up), e_up);
            chk("barrier_down", int'(barrier_down), e_dn);
            chk("lane_dir", int'(lane_dir), e_lane);
            chk("timeout_err", int'(timeout_err), e_err);
            if (lane_dir != 2'b00 && prev_lane == 2'b00)
                glog.push_back(int'(lane_dir));
            if (lane_dir != 2'b00 && !barrier_up && !barrier_down)
                obs_open++;
            if (timeout_err) obs_err++;
            prev_lane = lane_dir;
        end
        // advance the model with this cycle's inputs
        if (reset) begin
            m_busy      = 0;
            m_last_exit = 1;
            m_known     = 1;
        end else if (!m_busy) begin
            eo = entry_req && (int'(occupancy) < CAP);
            xo = exit_req;
            if (eo || xo) begin
                dx          = xo && (!eo || !m_last_exit);
                m_last_exit = dx;
                m_dir_exit  = dx;
                m_busy      = 1;
                m_t0        = cyc + 1;
                m_low       = -1;
                m_tout      = 0;
            end
        end else if (in_open()) begin
            k  = cyc - m_t0 - M;
            ps = m_dir_exit ? carOut : carIn;
            if (ps) begin
                m_low = cyc + 1;
            end else if (k == T - 1) begin
                m_low  = cyc + 1;
                m_tout = 1;
            end
        end else if (m_low >= 0 && cyc == m_low + M - 1) begin
            m_busy = 0;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int g0;
        k_rst = 1;
        run(2);
        k_rst = 0;

        // 1: basic entry
        k_occ = 0; k_en = 1; k_pass = 3;
        run(2);
        k_en = 0;
        run(20);
        chk("s1_grant", glog.size() > 0 ? glog[$] : -1, 1);
        chk("s1_err", obs_err, 0);

        // 2: capacity block, then exit
        g0 = glog.size();
        k_occ = 7; k_en = 1;
        run(30);
        chk("s2_nogrant", glog.size() - g0, 0);
        k_ex = 1;
        run(3);
        k_ex = 0;
        run(20);
        k_en = 0;
        chk("s2_exit", glog.size() > 0 ? glog[$] : -1, 2);

        // 3: round-robin
        glog.delete();
        k_occ = 3; k_en = 1; k_ex = 1; k_pass = 2;
        run(48);
        k_en = 0; k_ex = 0;
        run(15);
        chk("s3_n", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk("s3_order", glog[i], (i % 2 == 0) ? 1 : 2);

        // 4: timeout
        obs_open = 0; obs_err = 0;
        k_occ = 0; k_en = 1; k_pass = -1;
        run(2);
        k_en = 0;
        run(35);
        chk("s4_open", obs_open, T);
        chk("s4_err", obs_err, 1);

        // 5: wrong-direction pulse, pass in final cycle
        obs_open = 0; obs_err = 0;
        k_en = 1; k_pass = T - 1; k_wrong = 5;
        run(2);
        k_en = 0;
        run(35);
        chk("s5_open", obs_open, T);
        chk("s5_err", obs_err, 0);
        k_pass = 2; k_wrong = -1;

        // 6: reset during the second raise cycle
        k_en = 1;
        run(3);
        chk("s6_raising", int'(barrier_up), 1);
        k_rst = 1;
        step();
        k_rst = 0; k_ex = 1;
        step();
        chk("s6_up_drop", int'(barrier_up), 0);
        chk("s6_lane_clr", int'(lane_dir), 0);
        step();
        chk("s6_entry_first", int'(lane_dir), 1);
        k_en = 0; k_ex = 0;
        run(40);

        // random traffic
        k_rand = 1;
        run(3000);
        k_rand = 0;
        k_rst = 1;
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
